// File: rtl/e603_icb_ram_banked_pkg.sv
// Shared constants, address-split helpers and FSM encoding for the banked ICB RAM.
// All address-derived widths are computed here so the top and banks agree.
package e603_icb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Byte-offset bits inside one data word.
    function automatic int calc_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int calc_bank_bits(input int nbank);
        return $clog2(nbank);
    endfunction

    // Address bits that remain for the row once word offset and bank are stripped.
    function automatic int calc_row_aw(input int aw, input int dw, input int nbank);
        return aw - calc_lsb(dw) - calc_bank_bits(nbank);
    endfunction

    function automatic int calc_row_dp(input int mem_bytes, input int dw, input int nbank);
        return mem_bytes / (nbank * dw / 8);
    endfunction

    // Row index width actually needed to address ROW_DP entries.
    function automatic int calc_row_iw(input int row_dp);
        return (row_dp > 1) ? $clog2(row_dp) : 1;
    endfunction

endpackage

// File: rtl/e603_icb_ram_banked_if.sv
// ICB command/response channel between a bus master and the banked RAM slave.
// Both channels use valid/ready; a beat transfers when valid and ready are high together.
interface e603_icb_ram_banked_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic            icb_cmd_read;
    logic [AW-1:0]   icb_cmd_addr;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic [DW-1:0]   icb_rsp_rdata;
    logic            icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/e603_icb_ram_banked_bank.sv
// One RAM bank: single-port sync SRAM, byte-masked write, registered read (1 cycle).
// No backpressure; read data holds until the next read of this bank.
module e603_icb_ram_bank #(
    parameter int DW     = 32,
    parameter int ROW_DP = 2048,
    parameter int RIW    = 11
) (
    input  logic            clk,
    input  logic            cs,
    input  logic            we,
    input  logic [DW/8-1:0] wmask,
    input  logic [RIW-1:0]  row,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [ROW_DP];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (wmask[b]) mem[row][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata_q <= mem[row];
            end
        end
    end

    // Never-written rows read as zero in simulation rather than X.
`ifdef SYNTHESIS
    assign rdata = rdata_q;
`else
    assign rdata = $isunknown(rdata_q) ? '0 : rdata_q;
`endif
endmodule

// File: rtl/e603_icb_ram_banked.sv
// Banked ICB SRAM slave with programmable wait states and an in-order response FIFO.
// Latency 1+delay_select cycles; cmd_ready drops once RSP_DEPTH responses are outstanding.
module e603_icb_ram_banked
    import e603_icb_ram_pkg::*;
#(
    parameter int AW          = 14,
    parameter int DW          = 32,
    parameter int NBANK       = 2,
    parameter int MEM_BYTES   = 16384,
    parameter int DELAY_WIDTH = 4,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DELAY_WIDTH-1:0] delay_select,
    e603_icb_ram_banked_if.slave   icb,
    output logic [NBANK-1:0]       bank_busy
);
    localparam int LSB       = calc_lsb(DW);
    localparam int BANK_BITS = calc_bank_bits(NBANK);
    localparam int ROW_DP    = calc_row_dp(MEM_BYTES, DW, NBANK);
    localparam int RIW       = calc_row_iw(ROW_DP);
    localparam int BI        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WW        = AW - LSB;
    localparam int CW        = $clog2(RSP_DEPTH + 1);
    localparam int PW        = $clog2(RSP_DEPTH);

    state_t                 state_q, state_d;
    logic [DELAY_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0]          cnt_q;
    logic                   cmd_hs, rsp_hs;

    logic                   l_read;
    logic [AW-1:0]          l_addr;
    logic [DW-1:0]          l_wdata;
    logic [DW/8-1:0]        l_wmask;

    logic                   acc_en, acc_read, acc_err;
    logic [AW-1:0]          acc_addr;
    logic [DW-1:0]          acc_wdata;
    logic [DW/8-1:0]        acc_wmask;
    logic [WW-1:0]          acc_word;
    logic [BI-1:0]          acc_bank;
    logic [RIW-1:0]         acc_row;
    logic [NBANK-1:0]       cs;
    logic [DW-1:0]          bank_rdata [NBANK];

    logic                   p_vld, p_rd, p_err;
    logic [BI-1:0]          p_bank;
    logic [DW-1:0]          p_rdata;

    logic [DW-1:0]          f_data [RSP_DEPTH];
    logic                   f_err  [RSP_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          f_cnt;
    logic                   fifo_empty, push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready looks only at registered count: a same-cycle pop cannot free a slot.
    assign icb.icb_cmd_ready = (state_q == IDLE) && (cnt_q < CW'(RSP_DEPTH)) && !rst;
    assign cmd_hs = icb.icb_cmd_valid && icb.icb_cmd_ready;
    assign rsp_hs = icb.icb_rsp_valid && icb.icb_rsp_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs && delay_select != '0) begin
                    // The handshake cycle counts as the first wait cycle.
                    if (delay_select == DELAY_WIDTH'(1)) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = delay_select - DELAY_WIDTH'(1);
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == DELAY_WIDTH'(1)) state_d = ACCESS;
                else                           wcnt_d  = wcnt_q - DELAY_WIDTH'(1);
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            case ({cmd_hs, rsp_hs})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            l_read  <= icb.icb_cmd_read;
            l_addr  <= icb.icb_cmd_addr;
            l_wdata <= icb.icb_cmd_wdata;
            l_wmask <= icb.icb_cmd_wmask;
        end
    end

    // Zero-wait commands go straight from the bus; delayed ones from the latch.
    always_comb begin
        acc_en    = (state_q == ACCESS);
        acc_read  = l_read;
        acc_addr  = l_addr;
        acc_wdata = l_wdata;
        acc_wmask = l_wmask;
        if (state_q == IDLE && cmd_hs && delay_select == '0) begin
            acc_en    = 1'b1;
            acc_read  = icb.icb_cmd_read;
            acc_addr  = icb.icb_cmd_addr;
            acc_wdata = icb.icb_cmd_wdata;
            acc_wmask = icb.icb_cmd_wmask;
        end
    end

    assign acc_err  = 32'(acc_addr) >= MEM_BYTES;
    assign acc_word = acc_addr[AW-1:LSB];
    assign acc_bank = BI'(acc_word & WW'(NBANK - 1));
    assign acc_row  = RIW'(acc_word >> BANK_BITS);

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        assign cs[g] = acc_en && !acc_err && !rst && (acc_bank == BI'(g));
        e603_icb_ram_bank #(.DW(DW), .ROW_DP(ROW_DP), .RIW(RIW)) u_bank (
            .clk   (clk),
            .cs    (cs[g]),
            .we    (!acc_read),
            .wmask (acc_wmask),
            .row   (acc_row),
            .wdata (acc_wdata),
            .rdata (bank_rdata[g])
        );
    end
    assign bank_busy = cs;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld  <= 1'b0;
            p_rd   <= 1'b0;
            p_err  <= 1'b0;
            p_bank <= '0;
        end else begin
            p_vld  <= acc_en;
            p_rd   <= acc_read && !acc_err;
            p_err  <= acc_err;
            p_bank <= acc_bank;
        end
    end
    assign p_rdata = (p_vld && p_rd) ? bank_rdata[p_bank] : '0;

    // The post-access beat bypasses an empty FIFO so d=0 responds next cycle.
    assign fifo_empty = (f_cnt == '0);
    assign push       = p_vld && !(fifo_empty && icb.icb_rsp_ready);
    assign pop        = rsp_hs && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + CW'(1);
                2'b01:   f_cnt <= f_cnt - CW'(1);
                default: f_cnt <= f_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= p_rdata;
            f_err[wr_ptr]  <= p_err;
        end
    end

    assign icb.icb_rsp_valid = p_vld || !fifo_empty;
    assign icb.icb_rsp_rdata = fifo_empty ? p_rdata : f_data[rd_ptr];
    assign icb.icb_rsp_err   = fifo_empty ? (p_vld && p_err) : f_err[rd_ptr];
endmodule

// File: tb/tb_e603_icb_ram_banked.sv
// Directed bench for the banked ICB RAM: timing, masking, backpressure, range errors, reset.
module tb_e603_icb_ram_banked;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] delay_select = 4'd0;
    logic [1:0] bank_busy;
    int         errors = 0;
    int         checks = 0;

    e603_icb_ram_banked_if #(.AW(15), .DW(32)) icb ();

    always #5 clk = ~clk;

    e603_icb_ram_banked #(
        .AW(15), .DW(32), .NBANK(2), .MEM_BYTES(16384), .DELAY_WIDTH(4), .RSP_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .delay_select (delay_select),
        .icb          (icb),
        .bank_busy    (bank_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [14:0] a, input logic [31:0] wd, input logic [3:0] m);
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = m;
    endtask

    // Issue one command and return just after its accepting clock edge.
    task automatic send(input logic rd, input logic [14:0] a, input logic [31:0] wd, input logic [3:0] m);
        int n = 0;
        @(negedge clk);
        drive(rd, a, wd, m);
        #1;
        while (!icb.icb_cmd_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("cmd_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e);
        int n = 0;
        @(negedge clk);
        #1;
        while (!icb.icb_rsp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("rsp_timeout", 64'(n), 64'd0);
        d = icb.icb_rsp_rdata;
        e = icb.icb_rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_ready", icb.icb_cmd_ready, 0);
        check("rst_rsp_valid", icb.icb_rsp_valid, 0);
        check("rst_rsp_err",   icb.icb_rsp_err, 0);
        check("rst_rsp_rdata", icb.icb_rsp_rdata, 0);
        check("rst_bank_busy", bank_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        icb.icb_rsp_ready = 1'b1;
        #1;
        check("idle_cmd_ready", icb.icb_cmd_ready, 1);

        // Back-to-back write then read of 0x0004 with no wait states
        @(negedge clk);
        drive(1'b0, 15'h0004, 32'hDEADBEEF, 4'hF);
        #1;
        check("b2b_wr_ready", icb.icb_cmd_ready, 1);
        check("b2b_wr_bank",  bank_busy, 2'b10);
        @(negedge clk);
        drive(1'b1, 15'h0004, 32'h0, 4'h0);
        #1;
        check("b2b_rd_ready",  icb.icb_cmd_ready, 1);
        check("b2b_rd_bank",   bank_busy, 2'b10);
        check("b2b_wr_rsp",    icb.icb_rsp_valid, 1);
        check("b2b_wr_rdata",  icb.icb_rsp_rdata, 0);
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        #1;
        check("b2b_rd_rsp",   icb.icb_rsp_valid, 1);
        check("b2b_rd_rdata", icb.icb_rsp_rdata, 32'hDEADBEEF);
        check("b2b_rd_err",   icb.icb_rsp_err, 0);
        @(negedge clk);
        #1;
        check("b2b_drained", icb.icb_rsp_valid, 0);

        send(1'b0, 15'h0000, 32'h0BADF00D, 4'hF);
        wait_rsp(d, e);
        check("wr0_err", e, 0);

        // Three wait states; changing delay_select during WAIT must not matter
        @(negedge clk);
        delay_select = 4'd3;
        drive(1'b1, 15'h0000, 32'h0, 4'h0);
        #1;
        check("ws_ready", icb.icb_cmd_ready, 1);
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        delay_select = 4'd0;
        #1;
        check("ws_c1_ready", icb.icb_cmd_ready, 0);
        check("ws_c1_rsp",   icb.icb_rsp_valid, 0);
        @(negedge clk);
        #1;
        check("ws_c2_ready", icb.icb_cmd_ready, 0);
        check("ws_c2_rsp",   icb.icb_rsp_valid, 0);
        @(negedge clk);
        #1;
        check("ws_c3_ready", icb.icb_cmd_ready, 0);
        check("ws_c3_rsp",   icb.icb_rsp_valid, 0);
        check("ws_c3_bank",  bank_busy, 2'b01);
        @(negedge clk);
        #1;
        check("ws_c4_rsp",   icb.icb_rsp_valid, 1);
        check("ws_c4_rdata", icb.icb_rsp_rdata, 32'h0BADF00D);
        check("ws_c4_ready", icb.icb_cmd_ready, 1);

        // Byte-masked overwrite
        send(1'b0, 15'h0010, 32'h11223344, 4'hF);
        wait_rsp(d, e);
        send(1'b0, 15'h0010, 32'hAABBCCDD, 4'h5);
        wait_rsp(d, e);
        send(1'b1, 15'h0010, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("mask_rdata", d, 32'h11BB33DD);

        // Response backpressure with two outstanding slots
        @(negedge clk);
        icb.icb_rsp_ready = 1'b0;
        drive(1'b1, 15'h0004, 32'h0, 4'h0);
        #1;
        check("bp_ready1", icb.icb_cmd_ready, 1);
        @(negedge clk);
        drive(1'b1, 15'h0010, 32'h0, 4'h0);
        #1;
        check("bp_ready2", icb.icb_cmd_ready, 1);
        @(negedge clk);
        drive(1'b1, 15'h0000, 32'h0, 4'h0);
        #1;
        check("bp_stall1", icb.icb_cmd_ready, 0);
        check("bp_head",   icb.icb_rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        icb.icb_rsp_ready = 1'b1;
        #1;
        check("bp_stall2",   icb.icb_cmd_ready, 0);
        check("bp_rsp1",     icb.icb_rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("bp_accept3",  icb.icb_cmd_ready, 1);
        check("bp_rsp2",     icb.icb_rsp_rdata, 32'h11BB33DD);
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        #1;
        check("bp_rsp3_vld", icb.icb_rsp_valid, 1);
        check("bp_rsp3",     icb.icb_rsp_rdata, 32'h0BADF00D);
        @(negedge clk);
        #1;
        check("bp_drained",  icb.icb_rsp_valid, 0);

        // Out-of-range accesses just past MEM_BYTES
        send(1'b0, 15'h3FFC, 32'h11111111, 4'hF);
        wait_rsp(d, e);
        check("oor_last_err", e, 0);
        @(negedge clk);
        drive(1'b0, 15'h4000, 32'h22222222, 4'hF);
        #1;
        check("oor_wr_bank", bank_busy, 0);
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
        wait_rsp(d, e);
        check("oor_wr_err",   e, 1);
        check("oor_wr_rdata", d, 0);
        send(1'b1, 15'h4000, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("oor_rd_err",   e, 1);
        check("oor_rd_rdata", d, 0);
        @(negedge clk);
        #1;
        check("oor_idle_rsp",   icb.icb_rsp_valid, 0);
        check("oor_idle_ready", icb.icb_cmd_ready, 1);
        send(1'b1, 15'h3FFC, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("oor_keep_3ffc", d, 32'h11111111);
        send(1'b1, 15'h0000, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("oor_keep_0000", d, 32'h0BADF00D);

        // Reset during WAIT with a response still pending
        @(negedge clk);
        icb.icb_rsp_ready = 1'b0;
        send(1'b1, 15'h0004, 32'h0, 4'h0);
        delay_select = 4'd5;
        send(1'b1, 15'h0000, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        check("rstm_pending", icb.icb_rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("rstm_ready_in_rst", icb.icb_cmd_ready, 0);
        @(negedge clk);
        #1;
        check("rstm_rsp_dropped", icb.icb_rsp_valid, 0);
        check("rstm_ready_held",  icb.icb_cmd_ready, 0);
        check("rstm_bank_busy",   bank_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        delay_select = 4'd0;
        icb.icb_rsp_ready = 1'b1;
        #1;
        check("rstm_ready_after", icb.icb_cmd_ready, 1);
        check("rstm_rsp_after",   icb.icb_rsp_valid, 0);
        @(negedge clk);
        drive(1'b1, 15'h3FFC, 32'h0, 4'h0);
        #1;
        check("post_rst_ready", icb.icb_cmd_ready, 1);
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_latency", icb.icb_rsp_valid, 1);
        check("post_rst_rdata",   icb.icb_rsp_rdata, 32'h11111111);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
